motor_cmd_spi_rx: RTL and testbench

- SPI-slave command receiver: the upstream end of the motor drive path.
- Accepts 16-bit motor command frames from the balance-control MCU and presents registered sign/period pairs for the H-bridge PWM controller.
- Reads back the last committed command on MISO.
- A link watchdog forces the motors to a safe hold when the MCU stops sending.

---
 rtl/motor_cmd_spi_rx.sv | 175 +++++++++++++++++
 tb/tb_motor_cmd_spi_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_spi_rx.sv
// SPI-slave (mode 0) motor command receiver.
// Takes 16-bit frames {m1_sign, m1_period[6:0], m2_sign, m2_period[6:0]}.
// Presents the last good frame as registered motor commands.
// Returns the last committed frame on MISO during the following frame.
// A link watchdog forces a safe hold when the MCU goes quiet.
module motor_cmd_spi_rx #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2        // must be at least 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       motor1_sign,
    output logic [6:0] motor1_period,
    output logic       motor2_sign,
    output logic [6:0] motor2_period,
    output logic       cmd_valid,
    output logic       motor_hold,
    output logic       frame_err
);

    localparam int              WD_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      FRAME_BITS = 5'd16;
    localparam logic [4:0]      BIT_SAT    = 5'd17;

    typedef enum logic {IDLE, RECV} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_now, cs_now, mosi_now;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;

    logic [15:0]     shift_reg;
    logic [15:0]     miso_sr;
    logic [15:0]     readback;
    logic [4:0]      bit_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic start, shift_in, shift_out, commit, discard;

    assign sck_now  = sck_sync[SYNC_STAGES-1];
    assign cs_now   = cs_sync[SYNC_STAGES-1];
    assign mosi_now = mosi_sync[SYNC_STAGES-1];

    assign sck_rise = sck_now & ~sck_d;
    assign sck_fall = ~sck_now & sck_d;
    assign cs_rise  = cs_now & ~cs_d;
    assign cs_fall  = ~cs_now & cs_d;

    assign spi_miso = miso_sr[15];

    // Synchronize the SPI pins and keep a one-flop delayed copy for edge detection.
    // cs_n resets to 0 so that a frame already in progress when reset lifts never
    // produces a falling edge; its eventual rise is seen in IDLE and ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // stage's old value, which is what makes this a real shift chain.
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_now;
            cs_d      <= cs_now;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves one unassigned (which would infer a latch).
        state_next = state;
        start      = 1'b0;
        shift_in   = 1'b0;
        shift_out  = 1'b0;
        commit     = 1'b0;
        discard    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = RECV;
                    start      = 1'b1;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    if (bit_cnt == FRAME_BITS) commit  = 1'b1;
                    else                       discard = 1'b1;
                end else begin
                    shift_in  = sck_rise;
                    shift_out = sck_fall;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Receive shifter, saturating bit counter, MISO shifter and readback register.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            miso_sr   <= '0;
            readback  <= '0;
        end else begin
            if (start) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                miso_sr   <= readback;
            end else begin
                if (shift_in) begin
                    shift_reg <= {shift_reg[14:0], mosi_now};
                    if (bit_cnt != BIT_SAT) bit_cnt <= bit_cnt + 5'd1;
                end
                if (shift_out) miso_sr <= {miso_sr[14:0], 1'b0};
            end
            if (commit) readback <= shift_reg;
        end
    end

    // Motor command outputs, strobes and link watchdog; a commit beats a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            motor1_sign   <= 1'b0;
            motor1_period <= '0;
            motor2_sign   <= 1'b0;
            motor2_period <= '0;
            cmd_valid     <= 1'b0;
            frame_err     <= 1'b0;
            motor_hold    <= 1'b1;
            wd_cnt        <= '0;
        end else begin
            cmd_valid <= commit;
            frame_err <= discard;
            if (commit) begin
                motor1_sign   <= shift_reg[15];
                motor1_period <= shift_reg[14:8];
                motor2_sign   <= shift_reg[7];
                motor2_period <= shift_reg[6:0];
                motor_hold    <= 1'b0;
                wd_cnt        <= '0;
            end else if (!motor_hold) begin
                if (wd_cnt == WD_LAST) begin
                    motor1_sign   <= 1'b0;
                    motor1_period <= '0;
                    motor2_sign   <= 1'b0;
                    motor2_period <= '0;
                    motor_hold    <= 1'b1;
                    wd_cnt        <= '0;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// Bench for motor_cmd_spi_rx. Two instances share the SPI bus: dut_a has a
// watchdog far longer than the run, dut_w uses a 50-cycle watchdog.
module tb_motor_cmd_spi_rx;

    localparam int HALF       = 8;   // sck half period in clk cycles (clk/16)
    localparam int WD_TIMEOUT = 50;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic spi_sck  = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;

    logic       miso_a, s1_a, s2_a, cv_a, hold_a, fe_a;
    logic [6:0] p1_a, p2_a;
    logic       miso_w, s1_w, s2_w, cv_w, hold_w, fe_w;
    logic [6:0] p1_w, p2_w;

    always #5 clk = ~clk;

    motor_cmd_spi_rx #(.TIMEOUT_CYCLES(100000), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso_a),
        .motor1_sign(s1_a), .motor1_period(p1_a),
        .motor2_sign(s2_a), .motor2_period(p2_a),
        .cmd_valid(cv_a), .motor_hold(hold_a), .frame_err(fe_a)
    );

    motor_cmd_spi_rx #(.TIMEOUT_CYCLES(WD_TIMEOUT), .SYNC_STAGES(2)) dut_w (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso_w),
        .motor1_sign(s1_w), .motor1_period(p1_w),
        .motor2_sign(s2_w), .motor2_period(p2_w),
        .cmd_valid(cv_w), .motor_hold(hold_w), .frame_err(fe_w)
    );

    int checks   = 0;
    int errors   = 0;
    int cv_count = 0;
    int fe_count = 0;
    logic cv_prev = 1'b0;
    logic fe_prev = 1'b0;

    typedef struct {
        logic        is_commit;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    logic [15:0] miso_a_seen, miso_w_seen;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_fields_a(input string tag, input logic s1, input logic [6:0] p1,
                                  input logic s2, input logic [6:0] p2);
        check({tag, ".s1"}, s1_a, s1);
        check({tag, ".p1"}, p1_a, p1);
        check({tag, ".s2"}, s2_a, s2);
        check({tag, ".p2"}, p2_a, p2);
    endtask

    task automatic check_fields_w(input string tag, input logic s1, input logic [6:0] p1,
                                  input logic s2, input logic [6:0] p2);
        check({tag, ".s1"}, s1_w, s1);
        check({tag, ".p1"}, p1_w, p1);
        check({tag, ".s2"}, s2_w, s2);
        check({tag, ".p2"}, p2_w, p2);
    endtask

    // One SPI bit: MOSI set while sck low, MISO captured just before the rise.
    task automatic clock_bit(input logic b, input int idx);
        spi_mosi = b;
        repeat (HALF) @(negedge clk);
        if (idx < 16) begin
            miso_a_seen[15-idx] = miso_a;
            miso_w_seen[15-idx] = miso_w;
        end
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    // Full framed transfer of nbits (MSB first); pushes the expected outcome.
    task automatic send_frame(input logic [16:0] data, input int nbits);
        exp_t e;
        @(negedge clk);
        spi_cs_n    = 1'b0;
        miso_a_seen = '0;
        miso_w_seen = '0;
        for (int i = 0; i < nbits; i++) clock_bit(data[nbits-1-i], i);
        repeat (HALF) @(negedge clk);
        e.is_commit = (nbits == 16);
        e.data      = data[15:0];
        sb.push_back(e);
        spi_cs_n = 1'b1;
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    // Scoreboard monitor on dut_a: every cmd_valid/frame_err pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cv_prev) check("cmd_valid_width", cv_a, 1'b0);
        if (fe_prev) check("frame_err_width", fe_a, 1'b0);
        if (cv_a) cv_count++;
        if (fe_a) fe_count++;
        if (cv_a || fe_a) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_event", {cv_a, fe_a}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("sb_kind", {cv_a, fe_a}, e.is_commit ? 2'b10 : 2'b01);
                if (e.is_commit)
                    check("sb_data", {s1_a, p1_a, s2_a, p2_a}, e.data);
            end
        end
        cv_prev = cv_a;
        fe_prev = fe_a;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int cv_base;
        int fe_base;
        logic [15:0] partial;

        // Reset, then idle bus.
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check_fields_a("rst", 1'b0, 7'd0, 1'b0, 7'd0);
        check("rst_hold_a", hold_a, 1'b1);
        check("rst_hold_w", hold_w, 1'b1);
        check("rst_miso", miso_a, 1'b0);
        check("rst_cv_count", cv_count, 0);
        check("rst_fe_count", fe_count, 0);

        // First frame with exact commit latency (E0+2).
        send_frame(17'h0A53C, 16);
        @(negedge clk); check("lat_e0", cv_a, 1'b0);
        @(negedge clk); check("lat_e0p1", cv_a, 1'b0);
        @(negedge clk); check("lat_e0p2", cv_a, 1'b1);
        check_fields_a("a53c", 1'b1, 7'h25, 1'b0, 7'h3C);
        check("a53c_hold", hold_a, 1'b0);
        check("a53c_miso_readback", miso_a_seen, 16'h0000);
        settle();

        // Second frame: MISO returns the previous command.
        send_frame(17'h00102, 16);
        settle();
        check("0102_miso_readback", miso_a_seen, 16'hA53C);
        check_fields_a("0102", 1'b0, 7'd1, 1'b0, 7'd2);

        // Short and overrun frames after a valid 7F7F.
        send_frame(17'h07F7F, 16);
        settle();
        fe_base = fe_count;
        send_frame(17'h01234, 15);
        settle();
        check("short_fe_count", fe_count, fe_base + 1);
        send_frame(17'h1FFFF, 17);
        settle();
        check("overrun_fe_count", fe_count, fe_base + 2);
        check_fields_a("7f7f_kept", 1'b0, 7'h7F, 1'b0, 7'h7F);
        check("7f7f_hold", hold_a, 1'b0);

        // Period 0 is a legal stop command.
        send_frame(17'h08000, 16);
        settle();
        check_fields_a("stop", 1'b1, 7'd0, 1'b0, 7'd0);
        check("stop_hold", hold_a, 1'b0);

        // Watchdog on dut_w: hold exactly WD_TIMEOUT cycles after cmd_valid.
        send_frame(17'h01234, 16);
        n = 0;
        while (!cv_w && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wd_commit_seen", cv_w, 1'b1);
        check("wd_hold_after_commit", hold_w, 1'b0);
        check_fields_w("wd_commit", 1'b0, 7'h12, 1'b0, 7'h34);
        n = 0;
        while (!hold_w && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wd_hold_delay", n, WD_TIMEOUT);
        check_fields_w("wd_forced", 1'b0, 7'd0, 1'b0, 7'd0);
        check("wd_long_hold_a", hold_a, 1'b0);
        check_fields_a("wd_long_a", 1'b0, 7'h12, 1'b0, 7'h34);
        send_frame(17'h04321, 16);
        settle();
        check("wd_rearm_hold", hold_w, 1'b0);
        check_fields_w("wd_rearm", 1'b0, 7'h43, 1'b0, 7'h21);
        check("wd_readback_kept", miso_w_seen, 16'h1234);

        // Reset after 8 bits with cs_n held low, then 8 more bits.
        cv_base = cv_count;
        fe_base = fe_count;
        partial = 16'hA5C3;
        @(negedge clk);
        spi_cs_n = 1'b0;
        for (int i = 0; i < 8; i++) clock_bit(partial[15-i], i);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_hold", hold_a, 1'b1);
        check_fields_a("midrst", 1'b0, 7'd0, 1'b0, 7'd0);
        check("midrst_miso", miso_a, 1'b0);
        reset = 1'b0;
        for (int i = 8; i < 16; i++) clock_bit(partial[15-i], i);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        settle();
        check("midrst_no_commit", cv_count, cv_base);
        check("midrst_no_err", fe_count, fe_base);
        check("midrst_still_hold", hold_a, 1'b1);

        // Next full frame commits normally; readback was cleared by reset.
        send_frame(17'h0C35A, 16);
        settle();
        check("post_rst_commit", cv_count, cv_base + 1);
        check_fields_a("c35a", 1'b1, 7'h43, 1'b0, 7'h5A);
        check("c35a_hold", hold_a, 1'b0);
        check("c35a_miso_readback", miso_a_seen, 16'h0000);

        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
